// File: rtl/image_window_reader_if.sv
// Handshake bundle for image_window_reader: window request, buffer addr/dout channels and pixel stream.
interface image_window_reader_if #(
    parameter int unsigned W_DATA = 8,
    parameter int unsigned W_ADDR = 11,
    parameter int unsigned W_X    = 6,
    parameter int unsigned W_Y    = 6
);
    logic              start_valid;
    logic              start_ready;
    logic [W_X-1:0]    start_x;
    logic [W_Y-1:0]    start_y;
    logic              addr_valid;
    logic              addr_ready;
    logic [W_ADDR-1:0] addr_data;
    logic              din_valid;
    logic              din_ready;
    logic [W_DATA-1:0] din_data;
    logic              dout_valid;
    logic              dout_ready;
    logic [W_DATA-1:0] dout_data;
    logic              dout_eot;
    logic              busy;

    modport master (
        input  start_valid, start_x, start_y, addr_ready, din_valid, din_data, dout_ready,
        output start_ready, addr_valid, addr_data, din_ready, dout_valid, dout_data, dout_eot, busy
    );

    modport slave (
        output start_valid, start_x, start_y, addr_ready, din_valid, din_data, dout_ready,
        input  start_ready, addr_valid, addr_data, din_ready, dout_valid, dout_data, dout_eot, busy
    );
endinterface

// File: rtl/image_window_reader.sv
// Fetches a clamped WIN_WIDTH x WIN_HEIGHT window from the image buffer in raster order and
// streams the returned pixels downstream through a credit-protected return FIFO.
module image_window_reader #(
    parameter int unsigned W_DATA     = 8,
    parameter int unsigned IMG_WIDTH  = 45,
    parameter int unsigned IMG_HEIGHT = 45,
    parameter int unsigned WIN_WIDTH  = 24,
    parameter int unsigned WIN_HEIGHT = 24,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                   clk,
    input logic                   rst,
    image_window_reader_if.master bus
);
    localparam int unsigned W_ADDR = $clog2(IMG_WIDTH * IMG_HEIGHT);
    localparam int unsigned W_X    = $clog2(IMG_WIDTH);
    localparam int unsigned W_Y    = $clog2(IMG_HEIGHT);
    localparam int unsigned W_CNT  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned W_SUM  = W_CNT + 1;
    localparam int unsigned W_PTR  = $clog2(FIFO_DEPTH);
    localparam int unsigned N_PIX  = WIN_WIDTH * WIN_HEIGHT;
    localparam int unsigned W_POP  = $clog2(N_PIX);

    localparam logic [W_X-1:0]    X_MAX    = W_X'(IMG_WIDTH - WIN_WIDTH);
    localparam logic [W_Y-1:0]    Y_MAX    = W_Y'(IMG_HEIGHT - WIN_HEIGHT);
    localparam logic [W_X-1:0]    COL_LAST = W_X'(WIN_WIDTH - 1);
    localparam logic [W_Y-1:0]    ROW_LAST = W_Y'(WIN_HEIGHT - 1);
    localparam logic [W_POP-1:0]  POP_LAST = W_POP'(N_PIX - 1);
    localparam logic [W_PTR-1:0]  PTR_LAST = W_PTR'(FIFO_DEPTH - 1);
    localparam logic [W_ADDR-1:0] ROW_STEP = W_ADDR'(IMG_WIDTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                            state_q, state_d;
    logic [W_ADDR-1:0]                 row_base_q, row_base_d;
    logic [W_X-1:0]                    col_q, col_d;
    logic [W_Y-1:0]                    row_q, row_d;
    logic [W_CNT-1:0]                  out_cnt_q, out_cnt_d;
    logic [W_CNT-1:0]                  fifo_cnt_q, fifo_cnt_d;
    logic [W_PTR-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [W_PTR-1:0]                  rd_ptr_q, rd_ptr_d;
    logic [W_POP-1:0]                  pop_cnt_q, pop_cnt_d;
    logic [FIFO_DEPTH-1:0][W_DATA-1:0] mem_q, mem_d;

    logic [W_SUM-1:0] credit_sum_c;
    logic [W_X-1:0]   x_eff_c;
    logic [W_Y-1:0]   y_eff_c;
    logic             addr_valid_c, addr_hs_c, din_acc_c, dout_valid_c, pop_c, eot_c;

    // Handshake qualifiers; addr_valid uses registered counts only.
    always_comb begin
        credit_sum_c = W_SUM'(out_cnt_q) + W_SUM'(fifo_cnt_q);
        addr_valid_c = (state_q == ISSUE) && (credit_sum_c < W_SUM'(FIFO_DEPTH));
        addr_hs_c    = addr_valid_c && bus.addr_ready;
        din_acc_c    = bus.din_valid && (out_cnt_q != '0);
        dout_valid_c = (fifo_cnt_q != '0);
        pop_c        = dout_valid_c && bus.dout_ready;
        eot_c        = dout_valid_c && (pop_cnt_q == POP_LAST);
        x_eff_c      = (bus.start_x > X_MAX) ? X_MAX : bus.start_x;
        y_eff_c      = (bus.start_y > Y_MAX) ? Y_MAX : bus.start_y;
    end

    always_comb begin
        state_d    = state_q;
        row_base_d = row_base_q;
        col_d      = col_q;
        row_d      = row_q;
        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    row_base_d = W_ADDR'(y_eff_c) * ROW_STEP + W_ADDR'(x_eff_c);
                    col_d      = '0;
                    row_d      = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (addr_hs_c) begin
                    if (col_q == COL_LAST) begin
                        col_d      = '0;
                        row_base_d = row_base_q + ROW_STEP;
                        row_d      = row_q + W_Y'(1);
                        if (row_q == ROW_LAST) state_d = DRAIN;
                    end else begin
                        col_d = col_q + W_X'(1);
                    end
                end
            end
            DRAIN: begin
                // The eot pop is the last FIFO entry and nothing remains outstanding.
                if (pop_c && eot_c && (out_cnt_q == '0) && (fifo_cnt_q == W_CNT'(1)))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Credit counters and return FIFO.
    always_comb begin
        out_cnt_d  = out_cnt_q + W_CNT'(addr_hs_c) - W_CNT'(din_acc_c);
        fifo_cnt_d = fifo_cnt_q + W_CNT'(din_acc_c) - W_CNT'(pop_c);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pop_cnt_d  = pop_cnt_q;
        mem_d      = mem_q;
        if (din_acc_c) begin
            mem_d[wr_ptr_q] = bus.din_data;
            wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + W_PTR'(1);
        end
        if (pop_c) begin
            rd_ptr_d  = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + W_PTR'(1);
            pop_cnt_d = eot_c ? '0 : pop_cnt_q + W_POP'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            row_base_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            out_cnt_q  <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pop_cnt_q  <= '0;
            mem_q      <= '0;
        end else begin
            state_q    <= state_d;
            row_base_q <= row_base_d;
            col_q      <= col_d;
            row_q      <= row_d;
            out_cnt_q  <= out_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pop_cnt_q  <= pop_cnt_d;
            mem_q      <= mem_d;
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.addr_valid  = addr_valid_c;
    assign bus.addr_data   = row_base_q + W_ADDR'(col_q);
    assign bus.din_ready   = 1'b1;
    assign bus.dout_valid  = dout_valid_c;
    assign bus.dout_data   = dout_valid_c ? mem_q[rd_ptr_q] : '0;
    assign bus.dout_eot    = eot_c;
endmodule

// File: tb/tb_image_window_reader.sv
// Directed bench for image_window_reader: table of windows plus reset/stale-response sequence.
module tb_image_window_reader;
    localparam int NPIX = 576;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din_v_r = 1'b0;
    logic [7:0] din_d_r = 8'h00;
    logic inject_stale = 1'b0;

    int total = 0;
    int bad   = 0;

    image_window_reader_if #(.W_DATA(8), .W_ADDR(11), .W_X(6), .W_Y(6)) bus ();

    image_window_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input logic [10:0] a);
        int v;
        v = int'(a);
        return 8'(v * 37 + v / 32 + 1);
    endfunction

    // Image buffer model: one-cycle read latency, optional injected stale response.
    always @(posedge clk) begin
        din_v_r <= (bus.addr_valid && bus.addr_ready) || inject_stale;
        din_d_r <= inject_stale ? 8'hEE : pix(bus.addr_data);
    end
    assign bus.din_valid = din_v_r;
    assign bus.din_data  = din_d_r;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_addr(input int xe, input int ye, input int k);
        return (ye + k / 24) * 45 + xe + k % 24;
    endfunction

    typedef struct {
        int x;
        int y;
        bit rnd;
        int stall_at;
        int stall_len;
        int exp_first;
        int exp_last;
        int exp_lat;
    } vec_t;

    task automatic run_window(input int x, input int y, input bit rnd, input int stall_at,
                              input int stall_len, input int abort_at,
                              output int first_a, output int last_a, output int lat);
        int xe, ye, idx, pidx, issued, iss_lag, cyc, prev_addr, prev_dd, prev_eot;
        bit prev_astall, prev_dstall, saw_throttle;
        xe = (x > 21) ? 21 : x;
        ye = (y > 21) ? 21 : y;
        idx = 0; pidx = 0; issued = 0; iss_lag = 0; cyc = 0;
        prev_addr = 0; prev_dd = 0; prev_eot = 0;
        prev_astall = 0; prev_dstall = 0; saw_throttle = 0;
        first_a = -1; last_a = -1; lat = -1;
        chk("start_ready_idle", int'(bus.start_ready), 1);
        bus.start_x = 6'(x);
        bus.start_y = 6'(y);
        bus.start_valid = 1'b1;
        bus.addr_ready = 1'b1;
        bus.dout_ready = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (pidx < NPIX && cyc < 4000) begin
            if (abort_at > 0 && pidx == abort_at) return;
            // Start pulses while busy must be ignored.
            bus.start_valid = (cyc % 97 == 0);
            bus.start_x = 6'd3;
            bus.start_y = 6'd3;
            bus.addr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.dout_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            chk("busy", int'(bus.busy), 1);
            chk("start_ready_busy", int'(bus.start_ready), 0);
            chk("addr_valid", int'(bus.addr_valid), int'(idx < NPIX && (issued - pidx) < 4));
            chk("dout_valid", int'(bus.dout_valid), int'(iss_lag > pidx));
            if (idx < NPIX && (issued - pidx) >= 4 && !bus.addr_valid) saw_throttle = 1;
            if (prev_astall) chk("addr_hold", int'(bus.addr_data), prev_addr);
            if (prev_dstall) begin
                chk("dout_hold", int'(bus.dout_data), prev_dd);
                chk("eot_hold", int'(bus.dout_eot), prev_eot);
            end
            iss_lag = issued;
            if (bus.addr_valid && bus.addr_ready) begin
                chk("addr", int'(bus.addr_data), exp_addr(xe, ye, idx));
                if (idx == 0) first_a = int'(bus.addr_data);
                if (idx == NPIX - 1) last_a = int'(bus.addr_data);
                idx++;
                issued++;
            end
            if (bus.dout_valid && bus.dout_ready) begin
                chk("dout_data", int'(bus.dout_data), int'(pix(11'(exp_addr(xe, ye, pidx)))));
                chk("dout_eot", int'(bus.dout_eot), int'(pidx == NPIX - 1));
                if (pidx == NPIX - 1) lat = cyc;
                pidx++;
            end
            prev_astall = bus.addr_valid && !bus.addr_ready;
            prev_addr   = int'(bus.addr_data);
            prev_dstall = bus.dout_valid && !bus.dout_ready;
            prev_dd     = int'(bus.dout_data);
            prev_eot    = int'(bus.dout_eot);
            @(negedge clk);
            cyc++;
        end
        bus.start_valid = 1'b0;
        chk("window_done", pidx, NPIX);
        if (stall_len > 0) chk("throttle_seen", int'(saw_throttle), 1);
        chk("busy_after_eot", int'(bus.busy), 0);
        chk("start_ready_after_eot", int'(bus.start_ready), 1);
        chk("dout_valid_after_eot", int'(bus.dout_valid), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start_ready"}, int'(bus.start_ready), 1);
        chk({tag, "_addr_valid"}, int'(bus.addr_valid), 0);
        chk({tag, "_addr_data"}, int'(bus.addr_data), 0);
        chk({tag, "_din_ready"}, int'(bus.din_ready), 1);
        chk({tag, "_dout_valid"}, int'(bus.dout_valid), 0);
        chk({tag, "_dout_data"}, int'(bus.dout_data), 0);
        chk({tag, "_dout_eot"}, int'(bus.dout_eot), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        vec_t vecs[8];
        int fa, la, lt;
        vecs[0] = '{x: 0,  y: 0,  rnd: 0, stall_at: 0,   stall_len: 0,  exp_first: 0,   exp_last: 1058, exp_lat: 578};
        vecs[1] = '{x: 21, y: 21, rnd: 0, stall_at: 0,   stall_len: 0,  exp_first: 966, exp_last: 2024, exp_lat: 578};
        vecs[2] = '{x: 30, y: 40, rnd: 0, stall_at: 0,   stall_len: 0,  exp_first: 966, exp_last: 2024, exp_lat: 578};
        vecs[3] = '{x: 5,  y: 3,  rnd: 0, stall_at: 0,   stall_len: 0,  exp_first: 140, exp_last: 1198, exp_lat: 578};
        vecs[4] = '{x: 44, y: 0,  rnd: 0, stall_at: 0,   stall_len: 0,  exp_first: 21,  exp_last: 1079, exp_lat: 578};
        vecs[5] = '{x: 0,  y: 0,  rnd: 0, stall_at: 200, stall_len: 20, exp_first: 0,   exp_last: 1058, exp_lat: -1};
        vecs[6] = '{x: 7,  y: 9,  rnd: 1, stall_at: 0,   stall_len: 0,  exp_first: 412, exp_last: 1470, exp_lat: -1};
        vecs[7] = '{x: 0,  y: 0,  rnd: 1, stall_at: 100, stall_len: 20, exp_first: 0,   exp_last: 1058, exp_lat: -1};

        bus.start_valid = 1'b0;
        bus.start_x = '0;
        bus.start_y = '0;
        bus.addr_ready = 1'b0;
        bus.dout_ready = 1'b0;
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back windows: each start lands in the first IDLE cycle after the previous eot.
        for (int i = 0; i < 8; i++) begin
            run_window(vecs[i].x, vecs[i].y, vecs[i].rnd, vecs[i].stall_at, vecs[i].stall_len, 0,
                       fa, la, lt);
            chk($sformatf("v%0d_first_addr", i), fa, vecs[i].exp_first);
            chk($sformatf("v%0d_last_addr", i), la, vecs[i].exp_last);
            if (vecs[i].exp_lat >= 0) chk($sformatf("v%0d_latency", i), lt, vecs[i].exp_lat);
        end

        // Reset mid-window, then a stale response right after release.
        run_window(0, 0, 0, 0, 0, 100, fa, la, lt);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        bus.start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        inject_stale = 1'b1;
        @(negedge clk);
        inject_stale = 1'b0;
        chk("stale_din_present", int'(bus.din_valid), 1);
        @(negedge clk);
        chk("stale_dropped_0", int'(bus.dout_valid), 0);
        @(negedge clk);
        chk("stale_dropped_1", int'(bus.dout_valid), 0);
        run_window(0, 0, 0, 0, 0, 0, fa, la, lt);
        chk("post_rst_first_addr", fa, 0);
        chk("post_rst_last_addr", la, 1058);
        chk("post_rst_latency", lt, 578);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
